// File: rtl/prod_acc_pkg.sv
// Shared types and helpers for the product accumulator: FSM encoding,
// default widths, saturation limits and a width-generic sign extension.
package prod_acc_pkg;

    localparam int PROD_W_DEF = 64;
    localparam int ACC_W_DEF  = 64;
    localparam int CNT_W_DEF  = 16;
    localparam int MAX_W      = 128;

    localparam logic [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Replicates bit (w-1) of v into all higher bits; callers truncate to size.
    function automatic logic [MAX_W-1:0] sign_extend(input logic [MAX_W-1:0] v, input int w);
        logic [MAX_W-1:0] r;
        r = v;
        for (int i = 0; i < MAX_W; i++) begin
            if (i >= w) r[i] = v[w-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/product_accumulator_sat_add.sv
// Combinational signed saturating adder: clamps to the most positive or most
// negative ACC_W-bit value when the true sum does not fit.
module sat_add
    import prod_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             sat
);

    localparam logic [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] wide;

    assign wide = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    // Top two bits disagree exactly when the result left the ACC_W-bit range.
    assign sat  = wide[ACC_W] ^ wide[ACC_W-1];
    assign sum  = sat ? (wide[ACC_W] ? MIN_V : MAX_V) : wide[ACC_W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Accumulates a programmed number of signed products into a saturating sum
// and returns sum, count and sticky flags through a valid/ready handshake.
module product_accumulator
    import prod_acc_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_overflow,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_sat,
    output logic              out_ovf
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ACC_W-1:0] acc_q;
    logic             sat_q;
    logic             ovf_q;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] add_sum;
    logic             add_sat;
    logic             xfer;
    logic             last;
    logic             run_start;
    logic [CNT_W-1:0] cnt_inc;

    assign prod_ext = ACC_W'(sign_extend(MAX_W'(in_product), PROD_W));

    sat_add #(.ACC_W(ACC_W)) u_sat_add (
        .a   (acc_q),
        .b   (prod_ext),
        .sum (add_sum),
        .sat (add_sat)
    );

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign xfer      = in_ready & in_valid;
    assign run_start = (state_q == IDLE) & start;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign last      = (cnt_inc == len_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (len != '0) ? ACC : DONE;
            ACC:  if (xfer && last) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (run_start) begin
                len_q <= len;
                cnt_q <= '0;
                acc_q <= '0;
                sat_q <= 1'b0;
                ovf_q <= 1'b0;
            end else if (xfer) begin
                cnt_q <= cnt_inc;
                acc_q <= add_sum;
                sat_q <= sat_q | add_sat;
                ovf_q <= ovf_q | in_overflow;
            end
        end
    end

    // Registers are only written on start or transfer, so the result fields
    // stay put through DONE and after the handshake until the next run.
    assign out_sum   = acc_q;
    assign out_count = cnt_q;
    assign out_sat   = sat_q;
    assign out_ovf   = ovf_q;

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the 32x32 signed multiplier: accepts a stream of signed 64-bit products plus their overflow flag and accumulates a programmed number of them into a signed saturating sum (dot-product style).
- Presents the final sum, the transfer count and sticky status flags through a valid/ready output handshake.
- Sits between the multiplier result bus and the result/writeback logic.

Parameters:
- PROD_W, 64, width of the incoming signed product.
- ACC_W, 64, accumulator and result width; must be >= PROD_W.
- CNT_W, 16, width of the length and count fields.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- len  in  CNT_W  number of products in the run, latched on start.
- busy  out  1  high in ACC or DONE.
- in_valid  in  1  product present.
- in_ready  out  1  accumulator accepts a product.
- in_product  in  PROD_W  signed product.
- in_overflow  in  1  multiplier overflow flag for this product.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  ACC_W  signed accumulated sum.
- out_count  out  CNT_W  products accumulated.
- out_sat  out  1  sticky: saturation occurred in this run.
- out_ovf  out  1  sticky: any accepted product had in_overflow=1.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; accumulator, count, len register and flags are all 0.
  - Every output is 0: busy, in_ready, out_valid, out_sum, out_count, out_sat, out_ovf.
  - Reset mid-run discards the run without a result.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 with len!=0: latch len, clear accumulator, count and flags; next state ACC.
  - start=1 with len==0: clear the same registers; next state DONE (sum 0, count 0).
- ACC:
  - in_ready=1, driven combinationally from the state.
  - A transfer occurs when in_valid & in_ready.
  - On each transfer:
    - acc <= sat(acc + sign_extend(in_product)).
    - count <= count + 1.
    - ovf <= ovf | in_overflow.
    - sat <= sat | saturated.
  - When the transfer count reaches len, go to DONE on the same edge. No further product is accepted in that run.
  - in_valid low simply stalls the run; there is no timeout.
- Arithmetic:
  - Sum is formed at ACC_W+1 bits.
  - If the top two bits differ, clamp to +2^(ACC_W-1)-1 when positive overflow, or to -2^(ACC_W-1) when negative.
- DONE:
  - out_valid=1.
  - out_sum, out_count, out_sat and out_ovf are held stable until the handshake.
  - On out_valid & out_ready, go to IDLE; out_valid drops on the next cycle.
  - The output fields keep their last values until the next start.
- start asserted in ACC or DONE is ignored; it is not queued.
- Throughput and latency:
  - One product per cycle while in_valid is held high.
  - out_valid rises on the cycle after the final transfer.
  - For len=N with no stalls: start at cycle 0, transfers in cycles 1..N, out_valid in cycle N+1.
- The count never wraps, because len bounds it.

Decomposition:
- Package prod_acc_pkg:
  - state enum {IDLE, ACC, DONE}.
  - ACC_MAX and ACC_MIN constants.
  - a sign_extend function.
- One sub-module, sat_add: combinational signed saturating adder with inputs a[ACC_W], b[ACC_W] and outputs sum[ACC_W], sat.
- The FSM, counter and registers stay in product_accumulator.

Test Plan:
- Basic run: len=3, products 5, -2, 10 back-to-back -> out_sum=13, out_count=3, out_sat=0, out_ovf=0; out_valid exactly one cycle after the third transfer.
- Saturation: len=3, products 0x7FFF_FFFF_FFFF_FFFF, 1, -1 -> after the 2nd transfer acc=0x7FFF_FFFF_FFFF_FFFF; final out_sum=0x7FFF_FFFF_FFFF_FFFE, out_sat=1. Mirror case with 0x8000_0000_0000_0000 and -1 -> clamp to the minimum value.
- Backpressure and gaps: len=4 with in_valid gaps of 2 cycles, then out_ready held low 5 cycles -> sum and count correct, outputs stable while waiting, in_ready=0 in DONE, a start pulse in DONE is ignored.
- Zero length: start with len=0 -> out_valid on the next cycle with out_sum=0, out_count=0; no product accepted.
- Overflow propagation: len=2, in_overflow=1 on the 2nd product -> out_ovf=1. The next run with clean inputs -> out_ovf=0.
- Reset mid-run: rst_n low after 2 of 4 transfers -> all outputs 0 immediately (asynchronous). After release, a new run with len=1 and product -7 -> out_sum=-7.
